gigabit_egress_fifo: RTL

//  Per-port egress frame FIFO on the switch fabric clock. Accepts 64-bit frames from the crossbar output for one

---
 rtl/gigabit_egress_fifo.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/gigabit_egress_fifo.sv
// gigabit_egress_fifo: per-port store-and-forward egress FIFO on the fabric clock.
// Takes 64-bit crossbar beats, stores them in RAM, and commits only complete
// error-free frames. Committed frames are replayed as a 32-bit stream toward
// the port CDC/MAC.
// Optional feature macro: EGRESS_FIFO_STATS_EN enables the saturating
// frames_dropped / frames_sent counters. Without it both outputs are tied to 0.
module gigabit_egress_fifo #(
   parameter int DEPTH     = 512,
   parameter int USE_BLOCK = 1
) (
   input  logic                     clk,
   input  logic                     areset_n,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   input  logic [63:0]              s_tdata,
   input  logic [7:0]               s_tkeep,
   input  logic                     s_tlast,
   input  logic                     s_tuser,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic [31:0]              m_tdata,
   output logic [3:0]               m_tkeep,
   output logic                     m_tlast,
   output logic [$clog2(DEPTH):0]   fifo_free,
   output logic [31:0]              frames_dropped,
   output logic [31:0]              frames_sent
);
   localparam int ADDR_BITS = $clog2(DEPTH);
   localparam int PW        = ADDR_BITS + 1;
   localparam int WW        = 68;

   typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_LO, RD_HI} rd_state_t;

   logic [WW-1:0]        mem [DEPTH];
   logic [PW-1:0]        wr_ptr, wr_ptr_committed, rd_ptr, rd_ptr_next1;
   logic                 drop;
   logic                 wr_accept, wr_en, wr_good, full, empty, more;
   logic [2:0]           bytecount;
   logic [WW-1:0]        rd_word;
   logic                 rd_en, rd_pop;
   logic [ADDR_BITS-1:0] rd_addr;
   rd_state_t            state, state_next;
   logic                 w_last, short_word;
   logic [2:0]           w_bc;
   logic [3:0]           lo_keep, hi_keep;

   assign wr_accept    = s_tvalid & s_tready;
   assign full         = (wr_ptr - rd_ptr) == PW'(DEPTH);
   assign wr_en        = wr_accept & ~drop & ~full;
   assign wr_good      = ~drop & ~full & ~s_tuser;
   assign empty        = rd_ptr == wr_ptr_committed;
   assign rd_ptr_next1 = rd_ptr + PW'(1);
   assign more         = rd_ptr_next1 != wr_ptr_committed;
   assign fifo_free    = PW'(DEPTH) - (wr_ptr - rd_ptr);

   // Byte count of the beat; a 3-bit sum wraps 8 enabled bytes to the 0 encoding
   always_comb begin
      bytecount = '0;
      for (int unsigned i = 0; i < 8; i++) bytecount = bytecount + 3'(s_tkeep[i]);
   end

   // Write side: pointer advance, overflow drop flag and frame commit/rollback
   always_ff @(posedge clk) begin
      if (!areset_n) begin
         s_tready         <= 1'b0;
         wr_ptr           <= '0;
         wr_ptr_committed <= '0;
         drop             <= 1'b0;
      end else begin
         s_tready <= 1'b1;
         if (wr_accept) begin
            if (s_tlast) begin
               if (wr_good) begin
                  wr_ptr           <= wr_ptr + PW'(1);
                  wr_ptr_committed <= wr_ptr + PW'(1);
               end else begin
                  wr_ptr <= wr_ptr_committed;
               end
               drop <= 1'b0;
            end else if (full) begin
               drop <= 1'b1;
            end else if (!drop) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
         end
      end
   end

   // Frame storage; left unreset so it maps onto RAM
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[ADDR_BITS-1:0]] <= {s_tlast, bytecount, s_tdata};
   end

   generate
      if (USE_BLOCK != 0) begin : g_bram
         // Synchronous read port, output held until the next issued read
         always_ff @(posedge clk) begin
            if (rd_en) rd_word <= mem[rd_addr];
         end
      end else begin : g_dist
         logic [WW-1:0] async_word;
         assign async_word = mem[rd_addr];
         // Asynchronous array read registered to the same one-cycle latency
         always_ff @(posedge clk) begin
            if (rd_en) rd_word <= async_word;
         end
      end
   endgenerate

   assign w_last = rd_word[67];
   assign w_bc   = rd_word[66:64];

   // Byte enables for the two halves of the word being replayed
   always_comb begin
      lo_keep    = 4'hf;
      hi_keep    = 4'hf;
      short_word = 1'b0;
      case (w_bc)
         3'd1:    begin lo_keep = 4'h1; short_word = 1'b1; end
         3'd2:    begin lo_keep = 4'h3; short_word = 1'b1; end
         3'd3:    begin lo_keep = 4'h7; short_word = 1'b1; end
         3'd4:    begin lo_keep = 4'hf; short_word = 1'b1; end
         3'd5:    hi_keep = 4'h1;
         3'd6:    hi_keep = 4'h3;
         3'd7:    hi_keep = 4'h7;
         default: hi_keep = 4'hf;
      endcase
   end

   // Read FSM state and read pointer
   always_ff @(posedge clk) begin
      if (!areset_n) begin
         state  <= RD_IDLE;
         rd_ptr <= '0;
      end else begin
         state <= state_next;
         if (rd_pop) rd_ptr <= rd_ptr_next1;
      end
   end

   // Read FSM next state and port outputs; the final beat of a word prefetches the next one
   always_comb begin
      state_next = state;
      rd_en      = 1'b0;
      rd_addr    = rd_ptr[ADDR_BITS-1:0];
      rd_pop     = 1'b0;
      m_tvalid   = 1'b0;
      m_tdata    = '0;
      m_tkeep    = '0;
      m_tlast    = 1'b0;
      case (state)
         RD_IDLE: begin
            if (!empty) state_next = RD_FETCH;
         end
         RD_FETCH: begin
            rd_en      = 1'b1;
            state_next = RD_LO;
         end
         RD_LO: begin
            m_tvalid = 1'b1;
            m_tdata  = rd_word[31:0];
            if (short_word) begin
               m_tkeep = lo_keep;
               m_tlast = w_last;
               if (m_tready) begin
                  rd_pop = 1'b1;
                  if (more) begin
                     rd_en      = 1'b1;
                     rd_addr    = rd_ptr_next1[ADDR_BITS-1:0];
                     state_next = RD_LO;
                  end else begin
                     state_next = RD_IDLE;
                  end
               end
            end else begin
               m_tkeep = 4'hf;
               if (m_tready) state_next = RD_HI;
            end
         end
         default: begin
            m_tvalid = 1'b1;
            m_tdata  = rd_word[63:32];
            m_tkeep  = hi_keep;
            m_tlast  = w_last;
            if (m_tready) begin
               rd_pop = 1'b1;
               if (more) begin
                  rd_en      = 1'b1;
                  rd_addr    = rd_ptr_next1[ADDR_BITS-1:0];
                  state_next = RD_LO;
               end else begin
                  state_next = RD_IDLE;
               end
            end
         end
      endcase
   end

`ifdef EGRESS_FIFO_STATS_EN
   logic drop_evt, sent_evt;
   assign drop_evt = wr_accept & s_tlast & ~wr_good;
   assign sent_evt = m_tvalid & m_tready & m_tlast;

   // Saturating frame statistics
   always_ff @(posedge clk) begin
      if (!areset_n) begin
         frames_dropped <= '0;
         frames_sent    <= '0;
      end else begin
         if (drop_evt && (frames_dropped != '1)) frames_dropped <= frames_dropped + 32'd1;
         if (sent_evt && (frames_sent != '1))    frames_sent    <= frames_sent + 32'd1;
      end
   end
`else
   assign frames_dropped = '0;
   assign frames_sent    = '0;
`endif

endmodule
